// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW datapath: path-code constants, traceback FSM
// states and default sizing.
package dtw_pkg;

    localparam int N_DEF  = 32;
    localparam int IW_DEF = 5;
    localparam int DW_DEF = 16;

    localparam logic [1:0] PATH_DIAG = 2'b11;
    localparam logic [1:0] PATH_UP   = 2'b10;
    localparam logic [1:0] PATH_LEFT = 2'b01;
    localparam logic [1:0] PATH_RST  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } tb_state_t;

endpackage

// File: rtl/dtw_path_mem.sv
// Path-decision memory: one 2N-bit row per write, combinational single-cell read.
// Not reset, so contents survive a reset of the traceback controller.
module dtw_path_mem
    import dtw_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_wr_row,
    input  logic [2*N-1:0] i_wr_data,
    input  logic [IW-1:0] i_rd_i,
    input  logic [IW-1:0] i_rd_j,
    output logic [1:0]    o_cell
);

    logic [2*N-1:0] r_mem [N];
    logic [2*N-1:0] w_row;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
    end

    assign w_row  = r_mem[i_rd_i];
    assign o_cell = w_row[{i_rd_j, 1'b0} +: 2];

endmodule

// File: rtl/dtw_traceback.sv
// DTW traceback: stores path-decision rows, then walks from (i_end, j_end) back
// to the origin, streaming one cell per valid/ready handshake.
module dtw_traceback
    import dtw_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = IW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           wr_valid,
    input  logic [IW-1:0]  wr_row,
    input  logic [2*N-1:0] wr_paths,
    input  logic           start,
    input  logic [IW-1:0]  i_end,
    input  logic [IW-1:0]  j_end,
    input  logic [DW-1:0]  D_final,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IW-1:0]  out_i,
    output logic [IW-1:0]  out_j,
    output logic           out_last,
    output logic [DW-1:0]  o_dist,
    output logic           busy,
    output logic           done,
    output logic           o_err
);

    tb_state_t     r_state;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [DW-1:0] r_dist;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [1:0]    w_cell;
    logic          w_we;
    logic          w_atOrigin;
    logic          w_bad;
    logic          w_last;
    logic [IW-1:0] w_nextI;
    logic [IW-1:0] w_nextJ;

    // Writes are only honoured while idle so a running walk sees a frozen matrix.
    assign w_we = wr_valid && (r_state == ST_IDLE);

    dtw_path_mem #(.N(N), .IW(IW)) u_mem (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_row  (wr_row),
        .i_wr_data (wr_paths),
        .i_rd_i    (r_i),
        .i_rd_j    (r_j),
        .o_cell    (w_cell)
    );

    // A reset code is only an error off the edges; edge cells are forced.
    assign w_atOrigin = (r_i == '0) && (r_j == '0);
    assign w_bad      = (r_i != '0) && (r_j != '0) && (w_cell == PATH_RST);
    assign w_last     = (r_state == ST_WALK) && (w_atOrigin || w_bad);

    always_comb begin
        w_nextI = r_i;
        w_nextJ = r_j;
        if (r_i == '0) begin
            w_nextJ = r_j - IW'(1);
        end else if (r_j == '0) begin
            w_nextI = r_i - IW'(1);
        end else begin
            case (w_cell)
                PATH_DIAG: begin
                    w_nextI = r_i - IW'(1);
                    w_nextJ = r_j - IW'(1);
                end
                PATH_UP:   w_nextI = r_i - IW'(1);
                PATH_LEFT: w_nextJ = r_j - IW'(1);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_dist  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_i     <= i_end;
                        r_j     <= j_end;
                        r_dist  <= D_final;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_err   <= w_bad;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_i <= w_nextI;
                            r_j <= w_nextJ;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign o_err     = r_err;
    assign o_dist    = r_dist;
    assign out_i     = r_i;
    assign out_j     = r_j;
    assign out_last  = w_last;

endmodule

// File: tb/tb_dtw_traceback.sv
// Self-checking bench for dtw_traceback: a matrix model predicts each walk as a
// queue of cells, and a negedge monitor compares every beat and status flag.
module tb_dtw_traceback;
    import dtw_pkg::*;

    localparam int N  = 32;
    localparam int IW = 5;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           wr_valid = 1'b0;
    logic [IW-1:0]  wr_row = '0;
    logic [2*N-1:0] wr_paths = '0;
    logic           start = 1'b0;
    logic [IW-1:0]  i_end = '0;
    logic [IW-1:0]  j_end = '0;
    logic [DW-1:0]  D_final = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [IW-1:0]  out_i;
    logic [IW-1:0]  out_j;
    logic           out_last;
    logic [DW-1:0]  o_dist;
    logic           busy;
    logic           done;
    logic           o_err;

    int checks = 0;
    int errors = 0;

    logic [1:0]    modelMem [N][N];
    int            qI [$];
    int            qJ [$];
    bit            qL [$];
    bit            walkArmed = 0;
    bit            pendingDone = 0;
    bit            curWalkErr = 0;
    bit            expErr = 0;
    logic [DW-1:0] curDist = '0;
    int            beats = 0;
    int            readyMode = 0;
    int            phase = 0;

    always #5 clk = ~clk;

    dtw_traceback #(.N(N), .IW(IW), .DW(DW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .wr_valid  (wr_valid),
        .wr_row    (wr_row),
        .wr_paths  (wr_paths),
        .start     (start),
        .i_end     (i_end),
        .j_end     (j_end),
        .D_final   (D_final),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_j     (out_j),
        .out_last  (out_last),
        .o_dist    (o_dist),
        .busy      (busy),
        .done      (done),
        .o_err     (o_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*N-1:0] packRow(input int r);
        logic [2*N-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[2*c +: 2] = modelMem[r][c];
        return v;
    endfunction

    // Expected walk: list every visited cell, stopping at the origin or a reset code.
    task automatic modelWalk(input int ie, input int je);
        int  i;
        int  j;
        bit  fin;
        bit  last;
        i = ie;
        j = je;
        fin = 0;
        qI.delete();
        qJ.delete();
        qL.delete();
        curWalkErr = 0;
        while (!fin) begin
            last = 0;
            if (i == 0 && j == 0) last = 1;
            else if (i != 0 && j != 0 && modelMem[i][j] == 2'b00) begin
                last = 1;
                curWalkErr = 1;
            end
            qI.push_back(i);
            qJ.push_back(j);
            qL.push_back(last);
            if (last) fin = 1;
            else if (i == 0) j--;
            else if (j == 0) i--;
            else if (modelMem[i][j] == 2'b11) begin i--; j--; end
            else if (modelMem[i][j] == 2'b10) i--;
            else j--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit wv, input int row, input bit st, input int ie, input int je,
                                 input logic [DW-1:0] d);
        wr_valid = wv;
        wr_row   = IW'(row);
        wr_paths = packRow(row);
        start    = st;
        i_end    = IW'(ie);
        j_end    = IW'(je);
        D_final  = d;
        tick();
        wr_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic writeRow(input int r);
        applyStimulus(1'b1, r, 1'b0, 0, 0, '0);
    endtask

    task automatic fillAll(input logic [1:0] code);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) modelMem[r][c] = code;
            writeRow(r);
        end
    endtask

    task automatic randomRow(input int r);
        for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 31) == 0) modelMem[r][c] = 2'b00;
            else modelMem[r][c] = 2'($urandom_range(1, 3));
        end
    endtask

    task automatic startWalk(input int ie, input int je, input logic [DW-1:0] d,
                             input bit withWrite, input int wrSel);
        if (withWrite) randomRow(wrSel);
        modelWalk(ie, je);
        curDist = d;
        beats = 0;
        phase = 0;
        applyStimulus(withWrite, wrSel, 1'b1, ie, je, d);
        walkArmed = 1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((walkArmed || pendingDone) && n < 400) begin
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            phase++;
            tick();
            n++;
        end
        if (walkArmed || pendingDone) begin
            checks++;
            errors++;
            $display("[TB] FAIL walk_timeout: still busy=%0b after %0d cycles, required idle", busy, n);
            walkArmed = 0;
            pendingDone = 0;
            qI.delete(); qJ.delete(); qL.delete();
        end
        out_ready = 1'b1;
    endtask

    // Compare process: every beat must match the head of the expected queue.
    always @(negedge clk) begin
        bit expValid;
        if (nrst) begin
            expValid = walkArmed && (qI.size() > 0);
            checkOutput("done", done, pendingDone);
            pendingDone = 0;
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("busy", busy, expValid);
            if (expValid) begin
                checkOutput("out_i", out_i, qI[0]);
                checkOutput("out_j", out_j, qJ[0]);
                checkOutput("out_last", out_last, qL[0]);
                checkOutput("o_dist", o_dist, curDist);
                checkOutput("o_err_walk", o_err, 0);
                if (out_ready) begin
                    beats++;
                    if (qL[0]) begin
                        walkArmed = 0;
                        pendingDone = 1;
                        expErr = curWalkErr;
                    end
                    void'(qI.pop_front());
                    void'(qJ.pop_front());
                    void'(qL.pop_front());
                end
            end else begin
                checkOutput("o_err_idle", o_err, expErr);
            end
        end
    end

    initial begin
        nrst = 1'b0;
        repeat (2) tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_i", out_i, 0);
        checkOutput("rst_out_j", out_j, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_o_dist", o_dist, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_o_err", o_err, 0);
        nrst = 1'b1;
        tick();

        // Pure diagonal from (3,3).
        fillAll(2'b11);
        readyMode = 0;
        startWalk(3, 3, 16'h0055, 0, 0);
        waitIdle();
        checkOutput("diag_beats", beats, 4);
        checkOutput("diag_err", o_err, 0);

        // Left codes everywhere: row 2 to column 0, then forced up.
        fillAll(2'b01);
        startWalk(2, 4, 16'h0123, 0, 0);
        waitIdle();
        checkOutput("edge_beats", beats, 7);

        // Backpressure with ready pattern 1,0,0.
        fillAll(2'b11);
        readyMode = 1;
        startWalk(2, 2, 16'h0200, 0, 0);
        waitIdle();
        checkOutput("bp_beats", beats, 3);
        readyMode = 0;

        // Reset code at (1,1) ends the walk with an error.
        modelMem[1][1] = 2'b00;
        writeRow(1);
        startWalk(2, 2, 16'h0300, 0, 0);
        waitIdle();
        checkOutput("inv_beats", beats, 2);
        checkOutput("inv_err_set", o_err, 1);
        startWalk(3, 0, 16'h0301, 0, 0);
        checkOutput("inv_err_cleared", o_err, 0);
        waitIdle();

        // Start and write during a walk are both ignored.
        startWalk(5, 5, 16'h01A3, 0, 0);
        wr_valid = 1'b1; wr_row = IW'(4); wr_paths = '0;
        start = 1'b1; i_end = IW'(7); j_end = IW'(2); D_final = 16'hFFFF;
        tick();
        wr_valid = 1'b0; start = 1'b0;
        waitIdle();
        checkOutput("ign_dist", o_dist, 16'h01A3);
        checkOutput("ign_beats", beats, 5);
        checkOutput("ign_err", o_err, 1);
        modelMem[1][1] = 2'b11;
        writeRow(1);
        startWalk(4, 4, 16'h0400, 0, 0);
        waitIdle();
        checkOutput("ign_row4_beats", beats, 5);

        // Asynchronous reset mid-walk, then replay the same walk.
        startWalk(20, 20, 16'h0500, 0, 0);
        repeat (3) tick();
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_out_i", out_i, 0);
        checkOutput("arst_o_dist", o_dist, 0);
        walkArmed = 0;
        pendingDone = 0;
        expErr = 0;
        qI.delete(); qJ.delete(); qL.delete();
        repeat (2) tick();
        nrst = 1'b1;
        tick();
        startWalk(20, 20, 16'h0501, 0, 0);
        waitIdle();
        checkOutput("arst_replay_beats", beats, 21);

        // Randomised matrices, endpoints, backpressure and same-cycle writes.
        readyMode = 2;
        for (int t = 0; t < 24; t++) begin
            int nRows;
            int r;
            nRows = $urandom_range(1, 6);
            for (int k = 0; k < nRows; k++) begin
                r = $urandom_range(0, N - 1);
                randomRow(r);
                writeRow(r);
            end
            startWalk($urandom_range(0, N - 1), $urandom_range(0, N - 1), DW'($urandom),
                      $urandom_range(0, 1), $urandom_range(0, N - 1));
            waitIdle();
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtw_traceback.md
Name: dtw_traceback

Overview:
- Downstream consumer of the DTW processing-element array.
- Captures the 2-bit path decisions (o_path codes) produced by the PE array, one row per write, into a local path memory.
- On start, walks backward from the end cell (i_end, j_end) to the origin (0,0) and streams the warping path out one cell per handshake.
- Latches the final accumulated distance alongside the walk.

Parameters:
N, 32, number of frames per sequence (rows and columns of the path matrix)
IW, 5, index width (clog2 N)
DW, 16, accumulated-distance width (matches PE D output)

Ports:
clk  input  1  clock
nrst  input  1  reset, asynchronous, active-low
wr_valid  input  1  path-row write strobe
wr_row  input  IW  row index i of the write
wr_paths  input  2*N  path codes for row i; cell j at bits [2j+1:2j]
start  input  1  begin traceback (one-cycle pulse)
i_end  input  IW  start row of the walk
j_end  input  IW  start column of the walk
D_final  input  DW  accumulated distance at (i_end, j_end)
out_valid  output  1  path beat valid
out_ready  input  1  downstream accepts beat
out_i  output  IW  row index of the current path cell
out_j  output  IW  column index of the current path cell
out_last  output  1  final beat of the walk
o_dist  output  DW  D_final latched at start
busy  output  1  walk in progress
done  output  1  one-cycle pulse after the last beat is accepted
o_err  output  1  walk hit code 00 off-origin; sticky until the next accepted start

Behaviour:
- Path codes: 2'b11 = (i-1, j-1); 2'b10 = (i-1, j); 2'b01 = (i, j-1); 2'b00 = reset/invalid.
- Reset values: out_valid=0, out_i=0, out_j=0, out_last=0, o_dist=0, busy=0, done=0, o_err=0, FSM=IDLE.
- The path memory array is not reset. Contents after reset are undefined until rewritten.
- FSM states: IDLE, WALK, DONE.
- IDLE:
  - wr_valid writes wr_paths into mem[wr_row] in the same cycle.
  - start loads cur_i=i_end, cur_j=j_end and o_dist=D_final, clears o_err, then moves to WALK.
  - If wr_valid and start are asserted in the same cycle, the write completes first. The walk sees the new row from its first beat.
- WALK:
  - busy=1 and out_valid=1; out_i/out_j equal cur_i/cur_j.
  - Outputs are registered, so the first beat appears the cycle after start (latency 1).
  - cell = mem[cur_i][cur_j], read combinationally.
  - Next-cell rule, priority order:
    - cur_i=0 and cur_j=0: out_last=1.
    - cur_i=0: force j-1.
    - cur_j=0: force i-1.
    - cell=11: (i-1, j-1).
    - cell=10: (i-1, j).
    - cell=01: (i, j-1).
    - cell=00: out_last=1 and o_err set on acceptance.
  - out_last is combinationally consistent with the current beat.
  - On out_valid & out_ready: if out_last, go to DONE; otherwise update cur_i/cur_j.
  - While out_ready=0, out_i/out_j/out_last hold stable. The walk never drops or repeats a beat.
  - Walk length is at most i_end + j_end + 1 beats.
- DONE: done=1 for exactly one cycle, busy=0, out_valid=0, then IDLE.
- Ignored events:
  - start while busy or in DONE.
  - wr_valid outside IDLE (no memory update).
  - wr_row or i_end/j_end >= N: behaviour undefined. The bench must not drive it.
- Reset mid-walk: everything returns to reset values asynchronously. No done pulse. Memory is retained.
- All index arithmetic is unsigned IW-bit. Decrements never occur at 0 because of the boundary forcing.

Decomposition:
- Shared package dtw_pkg holds:
  - path code constants PATH_DIAG=2'b11, PATH_UP=2'b10, PATH_LEFT=2'b01, PATH_RST=2'b00 (shared with the PE array);
  - FSM state encoding;
  - default N/IW/DW.
- One natural sub-module, dtw_path_mem: N x 2N-bit register array with a row write port and a combinational cell read port (i, j).
- The FSM and handshake live in dtw_traceback.

Test Plan:
- Pure diagonal: write code 11 in all cells, start (3,3), out_ready=1 -> beats (3,3), (2,2), (1,1), (0,0); out_last only on (0,0); done pulses 1 cycle after; o_err=0.
- Edge forcing: all cells 01, start (2,4) -> (2,4), (2,3), (2,2), (2,1), (2,0), (1,0), (0,0); 7 beats.
- Backpressure: diagonal matrix, start (2,2), out_ready toggles 1,0,0,1,... -> out_i/out_j stable during stalls; exactly 3 beats delivered; no duplicates.
- Invalid code: mem[1][1]=00, mem[2][2]=11, start (2,2) -> beats (2,2), (1,1); out_last on (1,1); o_err=1 after acceptance; o_err cleared by the next start.
- Ignored inputs: start and wr_valid asserted mid-walk -> walk unchanged; memory unchanged (read back via a later walk); o_dist equals the first D_final (e.g. 16'h01A3).
- Async reset during WALK -> out_valid/busy drop immediately; no done pulse; a subsequent start with no rewrite reproduces the same path.
